// File: rtl/init_seq.sv
// Power-on enable sequencer: turns the init level into a thermometer-coded enable
// ramp that rises in ascending order and falls in reverse, one step per 2^N cycles.
module init_seq #(
    parameter int N    = 22,
    parameter int NOUT = 4
) (
    input  logic            clk_in,
    input  logic            rstn,
    input  logic            ini,
    output logic [NOUT-1:0] en,
    output logic            ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    cnt_reg, cnt_next;
    logic [NOUT-1:0] en_reg, en_next;
    logic            ready_reg, ready_next;
    logic            busy_reg, busy_next;

    logic [NOUT-1:0] en_up;
    logic [NOUT-1:0] en_dn;
    logic            step;

    // Shift paths built per bit so the NOUT=1 case needs no special slicing.
    assign en_up[0]      = 1'b1;
    assign en_dn[NOUT-1] = 1'b0;
    generate
        for (genvar gi = 1; gi < NOUT; gi++) begin : g_shift
            assign en_up[gi]   = en_reg[gi-1];
            assign en_dn[gi-1] = en_reg[gi];
        end
    endgenerate

    assign step = (cnt_reg == {N{1'b1}});

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        en_next    = en_reg;
        case (state_reg)
            OFF: begin
                cnt_next = '0;
                if (ini) begin
                    state_next = UP;
                end
            end
            UP: begin
                // A falling ini beats a step that would fire on the same edge.
                if (!ini) begin
                    state_next = (en_reg == '0) ? OFF : DOWN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + N'(1);
                    if (step) begin
                        en_next = en_up;
                        if (&en_up) begin
                            state_next = ON;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            ON: begin
                cnt_next = '0;
                if (!ini) begin
                    state_next = DOWN;
                end
            end
            DOWN: begin
                if (ini) begin
                    state_next = UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + N'(1);
                    if (step) begin
                        en_next = en_dn;
                        if (en_dn == '0) begin
                            state_next = OFF;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = OFF;
                cnt_next   = '0;
                en_next    = '0;
            end
        endcase
    end

    always_comb begin
        ready_next = (state_next == ON);
        busy_next  = (state_next == UP) || (state_next == DOWN);
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            en_reg    <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            en_reg    <= en_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    assign en    = en_reg;
    assign ready = ready_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_init_seq.sv
// Bench for init_seq: level/direction reference model checked every cycle,
// plus directed scenarios with hand-computed enable patterns.
module tb_init_seq;

    localparam int N    = 2;
    localparam int NOUT = 4;
    localparam int STEP = 1 << N;

    logic            clk_in;
    logic            rstn;
    logic            ini;
    logic [NOUT-1:0] en;
    logic            ready;
    logic            busy;

    int checks;
    int errors;

    init_seq #(.N(N), .NOUT(NOUT)) dut (
        .clk_in (clk_in),
        .rstn   (rstn),
        .ini    (ini),
        .en     (en),
        .ready  (ready),
        .busy   (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: number of enables lit, direction of travel, cycles since travel began.
    int lvl;
    int dir;
    int t;

    initial begin : compare
        logic            s_ini, s_rstn;
        logic [NOUT-1:0] en_exp;
        logic [NOUT-1:0] en_inc;
        lvl = 0;
        dir = 0;
        t   = 0;
        forever begin
            @(posedge clk_in);
            s_ini  = ini;
            s_rstn = rstn;
            @(negedge clk_in);
            if (!s_rstn) begin
                lvl = 0; dir = 0; t = 0;
            end else if (dir == 0) begin
                if (lvl == 0 && s_ini) begin
                    dir = 1; t = 0;
                end else if (lvl == NOUT && !s_ini) begin
                    dir = -1; t = 0;
                end
            end else if ((dir == 1) != s_ini) begin
                dir = (dir == 1 && lvl == 0) ? 0 : -dir;
                t   = 0;
            end else begin
                t++;
                if (t % STEP == 0) begin
                    lvl += dir;
                    if (lvl == 0 || lvl == NOUT) begin
                        dir = 0; t = 0;
                    end
                end
            end
            en_exp = NOUT'((1 << lvl) - 1);
            chk("model_en", int'(en), int'(en_exp));
            chk("model_busy", int'(busy), int'(dir != 0));
            chk("model_ready", int'(ready), int'(lvl == NOUT && dir == 0));
            en_inc = en + 1'b1;
            chk("inv_thermometer", int'((en & en_inc) == '0), 1);
            chk("inv_ready_full_idle", int'(!ready || (&en && !busy)), 1);
            chk("inv_busy_ready_excl", int'(busy && ready), 0);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk_in);
    endtask

    initial begin : stim
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        ini  = 1'b0;
        cyc(2);
        chk("reset_en", int'(en), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_busy", int'(busy), 0);
        rstn = 1'b1;
        cyc(2);

        // Power-up ramp from OFF
        ini = 1'b1;
        cyc(1);  chk("up_busy_first", int'(busy), 1);
        cyc(4);  chk("up_en_1", int'(en), 4'b0001);
        cyc(4);  chk("up_en_2", int'(en), 4'b0011);
        cyc(4);  chk("up_en_3", int'(en), 4'b0111);
        cyc(3);  chk("up_busy_last", int'(busy), 1);
        cyc(1);  chk("up_en_4", int'(en), 4'b1111);
        chk("up_ready", int'(ready), 1);
        chk("up_busy_done", int'(busy), 0);

        // Power-down ramp from ON
        ini = 1'b0;
        cyc(1);  chk("dn_ready_drop", int'(ready), 0);
        chk("dn_en_held", int'(en), 4'b1111);
        cyc(4);  chk("dn_en_3", int'(en), 4'b0111);
        cyc(4);  chk("dn_en_2", int'(en), 4'b0011);
        cyc(4);  chk("dn_en_1", int'(en), 4'b0001);
        cyc(4);  chk("dn_en_0", int'(en), 4'b0000);
        chk("dn_busy_done", int'(busy), 0);

        // Partial up, partial down, resume up
        ini = 1'b1;
        cyc(9);  chk("rev_en_up2", int'(en), 4'b0011);
        ini = 1'b0;
        cyc(5);  chk("rev_en_dn1", int'(en), 4'b0001);
        cyc(1);
        ini = 1'b1;
        cyc(5);  chk("rev_en_resume2", int'(en), 4'b0011);
        cyc(8);  chk("rev_en_full", int'(en), 4'b1111);
        chk("rev_ready", int'(ready), 1);
        ini = 1'b0;
        cyc(17); chk("rev_en_off", int'(en), 4'b0000);

        // One-cycle ini pulse before the first step
        ini = 1'b1;
        cyc(1);  chk("pulse_busy", int'(busy), 1);
        ini = 1'b0;
        cyc(1);  chk("pulse_busy_off", int'(busy), 0);
        chk("pulse_en", int'(en), 0);
        cyc(6);  chk("pulse_en_later", int'(en), 0);

        // Reset in the middle of power-up
        ini = 1'b1;
        cyc(13); chk("rst_en_pre", int'(en), 4'b0111);
        rstn = 1'b0;
        cyc(1);  chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        rstn = 1'b1;
        cyc(4);  chk("rst_en_restart0", int'(en), 0);
        cyc(1);  chk("rst_en_restart1", int'(en), 4'b0001);
        cyc(12); chk("rst_en_full", int'(en), 4'b1111);
        ini = 1'b0;
        cyc(17); chk("rst_en_off", int'(en), 0);

        // ini falls on exactly the cycle a step would fire
        ini = 1'b1;
        cyc(5);  chk("tie_en_1", int'(en), 4'b0001);
        cyc(3);
        ini = 1'b0;
        cyc(1);  chk("tie_en_noshift", int'(en), 4'b0001);
        chk("tie_busy_down", int'(busy), 1);
        cyc(3);  chk("tie_en_hold", int'(en), 4'b0001);
        cyc(1);  chk("tie_en_off", int'(en), 0);
        chk("tie_busy_off", int'(busy), 0);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
